buzzer_tone_sequencer: RTL

//   Plays a melody on the buzzer PWM. Fetches note words from a synchronous note memory, drives the PWM period/duty pair for each note's duration, inserts a silent gap between notes, and stops on a terminator.

---
 rtl/buzzer_tone_sequencer_pkg.sv | 29 ++
 rtl/buzzer_tone_sequencer_beat_timer.sv | 56 +++++
 rtl/buzzer_tone_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/buzzer_tone_sequencer_pkg.sv
// Shared definitions for the buzzer tone sequencer: note word layout,
// FSM state encodings and width helpers for the beat timer.
package buzzer_tone_sequencer_pkg;

    // Width of the duration field at the top of each note word.
    localparam int unsigned DUR_W = 32'd8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // Prescaler width; a divide-by-one still needs a 1-bit register.
    function automatic int unsigned presc_width(input int unsigned beat_div);
        return (beat_div > 32'd1) ? $clog2(beat_div) : 32'd1;
    endfunction

    // Down-counter width: wide enough for a duration or the raw gap count.
    function automatic int unsigned count_width(input int unsigned gap_cyc);
        int unsigned w;
        w = $clog2(gap_cyc + 32'd1);
        return (w > DUR_W) ? w : DUR_W;
    endfunction

endpackage

// File: rtl/buzzer_tone_sequencer_beat_timer.sv
// Prescaled down-counter. In beat mode the count drops once every BEAT_DIV
// cycles; in raw mode it drops every cycle. expire is high during the last
// cycle of the programmed interval so the owner can leave on the next edge.
module buzzer_tone_sequencer_beat_timer
    import buzzer_tone_sequencer_pkg::*;
#(
    parameter int unsigned BEAT_DIV = 32'd50000,
    parameter int unsigned CW       = 32'd8,
    parameter int unsigned PW       = 32'd16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load,
    input  logic          raw,
    input  logic [CW-1:0] units,
    output logic          expire
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(BEAT_DIV - 32'd1);

    logic [PW-1:0] presc_r;
    logic [CW-1:0] count_r;
    logic          raw_r;
    logic          tick_s;

    assign tick_s = raw_r || (presc_r == PRESC_LAST);
    assign expire = (count_r == {{(CW-1){1'b0}}, 1'b1}) && tick_s;

    // Prescaler and unit counter; a zero count means the timer is parked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            raw_r   <= 1'b0;
        end else if (clear) begin
            presc_r <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            raw_r   <= 1'b0;
        end else if (load) begin
            presc_r <= {PW{1'b0}};
            count_r <= units;
            raw_r   <= raw;
        end else if (count_r != {CW{1'b0}}) begin
            if (tick_s) begin
                presc_r <= {PW{1'b0}};
                count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
            end
        end else begin
            presc_r <= presc_r;
        end
    end

endmodule

// File: rtl/buzzer_tone_sequencer.sv
// Melody player: fetches note words from a synchronous note memory, drives
// the PWM period/duty pair for each note's duration, inserts a silent gap
// between notes and stops on a zero-duration terminator or the last address.
module buzzer_tone_sequencer
    import buzzer_tone_sequencer_pkg::*;
#(
    parameter int unsigned N        = 32'd16,
    parameter int unsigned AW       = 32'd8,
    parameter int unsigned BEAT_DIV = 32'd50000,
    parameter int unsigned GAP_CYC  = 32'd250000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic [AW-1:0]   base_addr,
    input  logic [N-1:0]    duty_cfg,
    output logic            note_rd,
    output logic [AW-1:0]   note_addr,
    input  logic [N+7:0]    note_data,
    output logic [N-1:0]    pwm_period,
    output logic [N-1:0]    pwm_duty,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CW       = count_width(GAP_CYC);
    localparam int unsigned PW       = presc_width(BEAT_DIV);
    localparam int unsigned DUR_LSB  = N;
    localparam int unsigned DUR_MSB  = N + DUR_W - 32'd1;
    localparam int unsigned FREQ_MSB = N - 32'd1;
    // Period 0 keeps the PWM accumulator at 0, below an all-ones duty: pin low.
    localparam logic [N-1:0]  SILENT_PERIOD = {N{1'b0}};
    localparam logic [N-1:0]  SILENT_DUTY   = {N{1'b1}};
    localparam logic [AW-1:0] ADDR_LAST     = {AW{1'b1}};
    localparam logic          HAS_GAP       = (GAP_CYC != 32'd0);

    state_t          state_r, state_s;
    logic [AW-1:0]   addr_r, addr_s;
    logic [N-1:0]    duty_r, duty_s;
    logic [N-1:0]    period_r, period_s;
    logic [N-1:0]    pwm_duty_r, pwm_duty_s;
    logic            rd_r, rd_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic [DUR_W-1:0] dur_s;
    logic [N-1:0]    freq_s;
    logic            tmr_load_s, tmr_raw_s, tmr_clear_s, tmr_expire_s;
    logic [CW-1:0]   tmr_units_s;

    assign dur_s  = note_data[DUR_MSB:DUR_LSB];
    assign freq_s = note_data[FREQ_MSB:0];

    assign note_rd    = rd_r;
    assign note_addr  = addr_r;
    assign pwm_period = period_r;
    assign pwm_duty   = pwm_duty_r;
    assign busy       = busy_r;
    assign done       = done_r;

    buzzer_tone_sequencer_beat_timer #(
        .BEAT_DIV (BEAT_DIV),
        .CW       (CW),
        .PW       (PW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear_s),
        .load   (tmr_load_s),
        .raw    (tmr_raw_s),
        .units  (tmr_units_s),
        .expire (tmr_expire_s)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        duty_s      = duty_r;
        period_s    = period_r;
        pwm_duty_s  = pwm_duty_r;
        rd_s        = 1'b0;
        busy_s      = busy_r;
        done_s      = 1'b0;
        tmr_load_s  = 1'b0;
        tmr_raw_s   = 1'b0;
        tmr_clear_s = 1'b0;
        tmr_units_s = {CW{1'b0}};

        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_s = ST_FETCH;
                    addr_s  = base_addr;
                    duty_s  = duty_cfg;
                    busy_s  = 1'b1;
                    rd_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                if (dur_s == {DUR_W{1'b0}}) begin
                    state_s    = ST_FINISH;
                    done_s     = 1'b1;
                    busy_s     = 1'b0;
                    period_s   = SILENT_PERIOD;
                    pwm_duty_s = SILENT_DUTY;
                end else begin
                    state_s     = ST_PLAY;
                    tmr_load_s  = 1'b1;
                    tmr_units_s = CW'(dur_s);
                    if (freq_s != {N{1'b0}}) begin
                        period_s   = freq_s;
                        pwm_duty_s = duty_r;
                    end else begin
                        period_s   = SILENT_PERIOD;
                        pwm_duty_s = SILENT_DUTY;
                    end
                end
            end
            ST_PLAY: begin
                if (tmr_expire_s) begin
                    period_s   = SILENT_PERIOD;
                    pwm_duty_s = SILENT_DUTY;
                    if (HAS_GAP) begin
                        state_s     = ST_GAP;
                        tmr_load_s  = 1'b1;
                        tmr_raw_s   = 1'b1;
                        tmr_units_s = CW'(GAP_CYC);
                    end else if (addr_r == ADDR_LAST) begin
                        state_s = ST_FINISH;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end else begin
                        state_s = ST_FETCH;
                        addr_s  = addr_r + {{(AW-1){1'b0}}, 1'b1};
                        rd_s    = 1'b1;
                    end
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_GAP: begin
                if (!tmr_expire_s) begin
                    state_s = ST_GAP;
                end else if (addr_r == ADDR_LAST) begin
                    state_s = ST_FINISH;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    state_s = ST_FETCH;
                    addr_s  = addr_r + {{(AW-1){1'b0}}, 1'b1};
                    rd_s    = 1'b1;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s    = ST_IDLE;
                busy_s     = 1'b0;
                period_s   = SILENT_PERIOD;
                pwm_duty_s = SILENT_DUTY;
            end
        endcase

        // Abort overrides everything outside IDLE; no done pulse on abort.
        if (stop && (state_r != ST_IDLE)) begin
            state_s     = ST_IDLE;
            period_s    = SILENT_PERIOD;
            pwm_duty_s  = SILENT_DUTY;
            busy_s      = 1'b0;
            rd_s        = 1'b0;
            done_s      = 1'b0;
            tmr_load_s  = 1'b0;
            tmr_clear_s = 1'b1;
        end else begin
            tmr_clear_s = 1'b0;
        end
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            addr_r     <= {AW{1'b0}};
            duty_r     <= {N{1'b0}};
            period_r   <= SILENT_PERIOD;
            pwm_duty_r <= SILENT_DUTY;
            rd_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            addr_r     <= addr_s;
            duty_r     <= duty_s;
            period_r   <= period_s;
            pwm_duty_r <= pwm_duty_s;
            rd_r       <= rd_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

endmodule
